// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every handshake and memory bus signal around the
// three-port memory arbiter.
//
// Ports (as seen from the arbiter, modport slave):
//   if_req/if_addr           in   instruction fetch read request
//   if_gnt/if_rvalid/if_rdata out grant pulse, read valid, read data for IF
//   d_req/d_wr/d_addr/d_wdata in   CPU data port request
//   d_gnt/d_rvalid/d_rdata    out  grant pulse, read valid, read data for D
//   x_req/x_wr/x_addr/x_wdata in   loader/debug port request
//   x_gnt/x_rvalid/x_rdata    out  grant pulse, read valid, read data for X
//   mem_en/mem_wr/mem_addr/mem_wdata out  registered single-port RAM command
//   mem_rdata                 in   RAM read data, valid the cycle after a read
//   busy                      out  arbiter is granting or has a read in flight
// Modport master is the mirror image used by requesters and the RAM model.
interface mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 8
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          x_req;
    logic          x_wr;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    logic          x_gnt;
    logic          x_rvalid;
    logic [DW-1:0] x_rdata;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_wr, d_addr, d_wdata,
        input  x_req, x_wr, x_addr, x_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output x_gnt, x_rvalid, x_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_wr, d_addr, d_wdata,
        output x_req, x_wr, x_addr, x_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  x_gnt, x_rvalid, x_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port synchronous RAM
// between instruction fetch (IF, read-only), CPU data (D) and loader/debug (X).
// A request sampled in IDLE becomes a one-cycle GRANT with a registered RAM
// command; read data comes back to the issuing port one cycle later.
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   reset_  in   asynchronous active-low reset
//   bus     slave side of mem_arbiter_if (requester handshakes + RAM bus)
module mem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_,
    mem_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [1:0] PORT_IF = 2'd0;
    localparam logic [1:0] PORT_D  = 2'd1;
    localparam logic [1:0] PORT_X  = 2'd2;

    state_t        state;
    state_t        state_next;
    logic [2:0]    reqs;
    logic          any_req;
    logic [1:0]    ptr;
    logic [1:0]    pick;
    logic [1:0]    winner;
    logic          pick_wr;
    logic [AW-1:0] pick_addr;
    logic [DW-1:0] pick_wdata;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          rd_pend;
    logic [1:0]    rd_owner;
    logic          granting;

    // State register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the grant-cycle outputs. GRANT always lasts exactly one
    // cycle, so a held request is re-arbitrated every second cycle.
    always_comb begin
        state_next = state;
        granting   = 1'b0;
        case (state)
            IDLE:  if (any_req) state_next = GRANT;
            GRANT: begin
                granting   = 1'b1;
                state_next = IDLE;
            end
        endcase
        bus.mem_en    = granting;
        bus.mem_wr    = granting && wr_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.if_gnt    = granting && (winner == PORT_IF);
        bus.d_gnt     = granting && (winner == PORT_D);
        bus.x_gnt     = granting && (winner == PORT_X);
        bus.busy      = granting || rd_pend;
    end

    // Round-robin pick: search starts at the pointer port and wraps IF->D->X.
    // The IF port has no write path, so its command is always a read.
    always_comb begin
        reqs       = {bus.x_req, bus.d_req, bus.if_req};
        any_req    = |reqs;
        pick       = PORT_IF;
        pick_wr    = 1'b0;
        pick_addr  = bus.if_addr;
        pick_wdata = '0;
        case (ptr)
            PORT_D:  pick = reqs[1] ? PORT_D : (reqs[2] ? PORT_X : PORT_IF);
            PORT_X:  pick = reqs[2] ? PORT_X : (reqs[0] ? PORT_IF : PORT_D);
            default: pick = reqs[0] ? PORT_IF : (reqs[1] ? PORT_D : PORT_X);
        endcase
        case (pick)
            PORT_D: begin
                pick_wr    = bus.d_wr;
                pick_addr  = bus.d_addr;
                pick_wdata = bus.d_wdata;
            end
            PORT_X: begin
                pick_wr    = bus.x_wr;
                pick_addr  = bus.x_addr;
                pick_wdata = bus.x_wdata;
            end
            default: begin
                pick_wr    = 1'b0;
                pick_addr  = bus.if_addr;
                pick_wdata = '0;
            end
        endcase
    end

    // Command capture on the IDLE->GRANT edge, pointer rotation past the
    // winner, and read tracking: a read GRANT arms rd_pend for exactly the
    // following cycle, which is when the RAM presents its data.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ptr      <= PORT_IF;
            winner   <= PORT_IF;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= PORT_IF;
        end else begin
            rd_pend <= (state == GRANT) && !wr_q;
            if (state == GRANT) begin
                rd_owner <= winner;
            end
            if ((state == IDLE) && any_req) begin
                winner  <= pick;
                ptr     <= (pick == PORT_X) ? PORT_IF : pick + 2'd1;
                wr_q    <= pick_wr;
                addr_q  <= pick_addr;
                wdata_q <= pick_wdata;
            end
        end
    end

    // Read return: RAM data is shared by all ports but only shown to the
    // port whose read is completing, zero elsewhere.
    always_comb begin
        bus.if_rvalid = rd_pend && (rd_owner == PORT_IF);
        bus.d_rvalid  = rd_pend && (rd_owner == PORT_D);
        bus.x_rvalid  = rd_pend && (rd_owner == PORT_X);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;
        bus.x_rdata   = bus.x_rvalid  ? bus.mem_rdata : '0;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing one single-port synchronous memory among three requesters: instruction fetch (IF, read-only), CPU data port (D) and the external loader/debug port (X). Sits between the CPU core's fetch and data memory ports and a single unified program/data RAM. It converts per-port request/grant handshakes into a registered memory command stream and routes read data back to the issuing port.

## Interface
Parameters:
- AW, 12, address width (4 KiB space)
- DW, 8, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_  in  1  reset; asynchronous, active-low
- if_req  in  1  IF read request; held with if_addr until if_gnt
- if_addr  in  AW  IF read address
- if_gnt  out  1  one-cycle grant pulse to IF
- if_rvalid  out  1  IF read data valid
- if_rdata  out  DW  IF read data
- d_req  in  1  D request; held with d_wr/d_addr/d_wdata until d_gnt
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  AW  D address
- d_wdata  in  DW  D write data
- d_gnt, d_rvalid  out  1 each  D grant pulse, D read data valid
- d_rdata  out  DW  D read data
- x_req, x_wr, x_addr, x_wdata, x_gnt, x_rvalid, x_rdata: same as D port, for X
- mem_en  out  1  memory access strobe
- mem_wr  out  1  write enable (valid with mem_en)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after a read strobe
- busy  out  1  high in GRANT state or while a read is outstanding

## Operation
- Two-state FSM: IDLE, GRANT. Reset state IDLE.
- IDLE: sample if_req/d_req/x_req. If none, stay IDLE. Else pick winner by round-robin, go to GRANT; register winner's address/wdata/wr into mem_* and assert winner's gnt.
- GRANT (exactly 1 cycle): mem_en=1, chosen *_gnt=1, others 0. Requests are not sampled. Always return to IDLE.
- Round-robin order IF -> D -> X -> IF. Pointer = highest-priority port; after a grant it moves to the port following the winner. Reset pointer = IF.
- IF port is read-only: mem_wr forced 0 for IF grants.
- Read tracking: on a read GRANT, register rd_owner (2 bits) and rd_pend=1. Next cycle the owner's *_rvalid=1 for one cycle; rd_pend then clears unless a new read is granted.
- *_rdata is mem_rdata for all ports, gated to 0 when that port's rvalid is 0.
- Writes produce no rvalid.
- Requester protocol: hold req and fields stable until gnt is seen; after the gnt cycle it either deasserts req or presents the next request. Changing fields while req is high without gnt is illegal (undefined).
- A requester may hold req continuously to issue back-to-back accesses; each GRANT consumes one access.

## Timing
- Reset (async, immediate): state=IDLE, pointer=IF, all *_gnt=0, all *_rvalid=0, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, rd_pend=0, busy=0. Any outstanding read is discarded; no rvalid after reset release.
- Request sampled at edge E (IDLE) -> gnt and mem_en high in cycle E+1 -> read data/rvalid in cycle E+2.
- Max throughput: one access per 2 cycles. A read's rvalid cycle coincides with the next IDLE evaluation, so it overlaps with arbitration.
- Simultaneous requests: granted one per 2 cycles in rotating order. With all three held, sequence IF, D, X, IF, ... Worst-case wait for any port: 6 cycles from req to gnt.
- Single requester held continuously: grants every 2nd cycle regardless of pointer.
- busy is combinational from state and rd_pend.

## Test plan
- Reset: assert reset_=0 mid-GRANT of a D read -> mem_en, d_gnt and d_rvalid drop to 0 immediately; no d_rvalid after release. First grant after release goes to IF when all three request.
- Single read: mem holds 0x5A at 0x123; d_req=1, d_wr=0, d_addr=0x123 -> d_gnt and mem_en at +1 with mem_addr=0x123, mem_wr=0; d_rvalid=1 with d_rdata=0x5A at +2; if_rvalid and x_rvalid stay 0.
- Write: x_req, x_wr=1, x_addr=0xFFF, x_wdata=0xA5 -> one cycle with mem_en=1, mem_wr=1, mem_addr=0xFFF, mem_wdata=0xA5; no x_rvalid; reading 0xFFF via D returns 0xA5.
- Fairness: all three held for 12 cycles -> grants IF, D, X, IF, D, X on alternate cycles; no port waits more than 6 cycles.
- IF write protection: if_req with D idle -> mem_wr=0 on IF grant. Back-to-back reads IF@0x010 then D@0x020 -> if_rvalid and d_rvalid each arrive one cycle after their own grant with the correct data.
- Idle: no requests for 10 cycles -> mem_en=0, busy=0, FSM stays IDLE, pointer unchanged.
